multi_cycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the CPU datapath: a state machine that steps each instruction through
//  IF/ID/EXE/MEM/WB and drives the datapath control lines per state. Sits beside the PC, IR,

---
 rtl/multi_cycle_ctrl_if.sv | 50 +++++
 rtl/multi_cycle_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: bundles the sequencer's datapath-facing signals.
// The master side is the sequencer (drives control lines, reads opcode and ALU flags);
// the slave side is the datapath.
// Build option MCC_PERF_CNT_EN adds the cycle_cnt / instr_cnt performance counters.
interface multi_cycle_ctrl_if #(
    parameter int OPW = 6
`ifdef MCC_PERF_CNT_EN
    , parameter int CNTW = 32
`endif
);
    logic [OPW-1:0] Opcode;
    logic           zero;
    logic           sign;
    logic           PCWre;
    logic           IRWre;
    logic           InsMemRW;
    logic           ALUSrcA;
    logic           ALUSrcB;
    logic           DBDataSrc;
    logic           RegWre;
    logic           RegDst;
    logic           ExtSel;
    logic           mRD;
    logic           mWR;
    logic [1:0]     PCSrc;
    logic [2:0]     ALUOp;
    logic           halted;
`ifdef MCC_PERF_CNT_EN
    logic [CNTW-1:0] cycle_cnt;
    logic [CNTW-1:0] instr_cnt;
`endif

    modport master (
        input  Opcode, zero, sign,
        output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, RegDst,
               ExtSel, mRD, mWR, PCSrc, ALUOp, halted
`ifdef MCC_PERF_CNT_EN
        , output cycle_cnt, instr_cnt
`endif
    );

    modport slave (
        output Opcode, zero, sign,
        input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, RegDst,
               ExtSel, mRD, mWR, PCSrc, ALUOp, halted
`ifdef MCC_PERF_CNT_EN
        , input cycle_cnt, instr_cnt
`endif
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle CPU sequencer stepping each instruction through
// IF/ID/EXE/MEM/WB and decoding the datapath control lines from the current state and opcode.
// Build option MCC_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multi_cycle_ctrl #(
    parameter int OPW = 6
`ifdef MCC_PERF_CNT_EN
    , parameter int CNTW = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    multi_cycle_ctrl_if.master bus
);

    // The eight working states use every 3-bit code, so HALT needs a fourth bit to stay distinct.
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(6'b011000);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b110101);
    localparam logic [OPW-1:0] OP_BLTZ = OPW'(6'b110110);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

    state_t     r_state;

    logic       w_isAluOp;
    logic       w_isImmAlu;
    logic       w_isMem;
    logic       w_isBranch;
    logic       w_isJump;
    logic       w_isHalt;
    logic       w_isUnknown;
    logic [2:0] w_aluOpDec;
    logic       w_takeBranch;

    logic       w_pcWre;
    logic       w_irWre;
    logic       w_insMemRw;
    logic       w_aluSrcA;
    logic       w_aluSrcB;
    logic       w_dbDataSrc;
    logic       w_regWre;
    logic       w_regDst;
    logic       w_extSel;
    logic       w_mRd;
    logic       w_mWr;
    logic [1:0] w_pcSrc;
    logic [2:0] w_aluOp;
    logic       w_halted;

    // Classify the opcode into instruction groups and pick the ALU operation it needs.
    always_comb begin
        w_isAluOp   = 1'b0;
        w_isImmAlu  = 1'b0;
        w_isMem     = 1'b0;
        w_isBranch  = 1'b0;
        w_isJump    = 1'b0;
        w_isHalt    = 1'b0;
        w_isUnknown = 1'b0;
        w_aluOpDec  = 3'b000;
        case (bus.Opcode)
            OP_ADD:                  w_isAluOp = 1'b1;
            OP_SUB:  begin w_isAluOp = 1'b1; w_aluOpDec = 3'b001; end
            OP_ADDI: begin w_isAluOp = 1'b1; w_isImmAlu = 1'b1; end
            OP_OR:   begin w_isAluOp = 1'b1; w_aluOpDec = 3'b011; end
            OP_AND:  begin w_isAluOp = 1'b1; w_aluOpDec = 3'b100; end
            OP_ORI:  begin w_isAluOp = 1'b1; w_isImmAlu = 1'b1; w_aluOpDec = 3'b011; end
            OP_SLL:  begin w_isAluOp = 1'b1; w_aluOpDec = 3'b010; end
            OP_SLT:  begin w_isAluOp = 1'b1; w_aluOpDec = 3'b101; end
            OP_SW, OP_LW:            w_isMem = 1'b1;
            OP_BEQ, OP_BNE, OP_BLTZ: w_isBranch = 1'b1;
            OP_J:                    w_isJump = 1'b1;
            OP_HALT:                 w_isHalt = 1'b1;
            default:                 w_isUnknown = 1'b1;
        endcase
    end

    assign w_takeBranch = ((bus.Opcode == OP_BEQ)  &&  bus.zero) ||
                          ((bus.Opcode == OP_BNE)  && !bus.zero) ||
                          ((bus.Opcode == OP_BLTZ) &&  bus.sign);

    // Sequence the instruction phases; reset aborts whatever is in flight and restarts at IF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            case (r_state)
                S_IF:     r_state <= S_ID;
                S_ID: begin
                    if (w_isAluOp)       r_state <= S_EXE_AL;
                    else if (w_isMem)    r_state <= S_EXE_LS;
                    else if (w_isBranch) r_state <= S_EXE_BR;
                    else if (w_isHalt)   r_state <= S_HALT;
                    else                 r_state <= S_IF;
                end
                S_EXE_AL: r_state <= S_WB_AL;
                S_EXE_LS: r_state <= S_MEM;
                S_MEM:    r_state <= (bus.Opcode == OP_LW) ? S_WB_LD : S_IF;
                S_WB_AL:  r_state <= S_IF;
                S_WB_LD:  r_state <= S_IF;
                S_EXE_BR: r_state <= S_IF;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_IF;
            endcase
        end
    end

    // Decode control lines from state and opcode; everything is held low while reset is asserted.
    always_comb begin
        w_pcWre     = 1'b0;
        w_irWre     = 1'b0;
        w_insMemRw  = 1'b0;
        w_aluSrcA   = 1'b0;
        w_aluSrcB   = 1'b0;
        w_dbDataSrc = 1'b0;
        w_regWre    = 1'b0;
        w_regDst    = 1'b0;
        w_extSel    = 1'b0;
        w_mRd       = 1'b0;
        w_mWr       = 1'b0;
        w_pcSrc     = 2'b00;
        w_aluOp     = 3'b000;
        w_halted    = 1'b0;
        if (!reset) begin
            w_extSel = (bus.Opcode != OP_ORI);
            case (r_state)
                S_IF: begin
                    w_insMemRw = 1'b1;
                    w_irWre    = 1'b1;
                end
                S_ID: begin
                    if (w_isJump) begin
                        w_pcWre = 1'b1;
                        w_pcSrc = 2'b11;
                    end else if (w_isUnknown) begin
                        w_pcWre = 1'b1;
                    end
                end
                S_EXE_AL: begin
                    w_aluOp   = w_aluOpDec;
                    w_aluSrcB = w_isImmAlu;
                    w_aluSrcA = (bus.Opcode == OP_SLL);
                end
                S_EXE_LS: begin
                    w_aluOp   = 3'b000;
                    w_aluSrcB = 1'b1;
                end
                S_EXE_BR: begin
                    w_aluOp = 3'b001;
                    w_pcWre = 1'b1;
                    w_pcSrc = w_takeBranch ? 2'b01 : 2'b00;
                end
                S_MEM: begin
                    if (bus.Opcode == OP_LW) begin
                        w_mRd = 1'b1;
                    end else begin
                        w_mWr   = 1'b1;
                        w_pcWre = 1'b1;
                    end
                end
                S_WB_AL: begin
                    w_regWre = 1'b1;
                    w_pcWre  = 1'b1;
                    w_regDst = !w_isImmAlu;
                end
                S_WB_LD: begin
                    w_regWre    = 1'b1;
                    w_dbDataSrc = 1'b1;
                    w_pcWre     = 1'b1;
                end
                S_HALT:  w_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.PCWre     = w_pcWre;
    assign bus.IRWre     = w_irWre;
    assign bus.InsMemRW  = w_insMemRw;
    assign bus.ALUSrcA   = w_aluSrcA;
    assign bus.ALUSrcB   = w_aluSrcB;
    assign bus.DBDataSrc = w_dbDataSrc;
    assign bus.RegWre    = w_regWre;
    assign bus.RegDst    = w_regDst;
    assign bus.ExtSel    = w_extSel;
    assign bus.mRD       = w_mRd;
    assign bus.mWR       = w_mWr;
    assign bus.PCSrc     = w_pcSrc;
    assign bus.ALUOp     = w_aluOp;
    assign bus.halted    = w_halted;

`ifdef MCC_PERF_CNT_EN
    logic [CNTW-1:0] r_cycleCnt;
    logic [CNTW-1:0] r_instrCnt;

    // Count running cycles and retired instructions (one PC write per instruction), wrapping freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycleCnt <= '0;
            r_instrCnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycleCnt <= r_cycleCnt + 1'b1;
            if (w_pcWre)           r_instrCnt <= r_instrCnt + 1'b1;
        end
    end

    assign bus.cycle_cnt = r_cycleCnt;
    assign bus.instr_cnt = r_instrCnt;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: self-checking bench for the multi-cycle sequencer.
// With MCC_PERF_CNT_EN defined the performance counters are checked as well.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_UNK  = 6'b101010;

    typedef struct packed {
        logic       pcWre;
        logic       irWre;
        logic       insMemRw;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       dbDataSrc;
        logic       regWre;
        logic       regDst;
        logic       extSel;
        logic       mRd;
        logic       mWr;
        logic [1:0] pcSrc;
        logic [2:0] aluOp;
        logic       halted;
    } outs_t;

    typedef enum {K_ALU, K_LW, K_SW, K_BR, K_J, K_HALT, K_UNK} kind_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic       sign;
        logic [1:0] pcSrc;
        string      name;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    outs_t sb[$];
    int    total = 0;
    int    bad = 0;
    vec_t  vecs[18];

    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus();

    multi_cycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic kind_t kindOf(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT: return K_ALU;
            OP_LW:                   return K_LW;
            OP_SW:                   return K_SW;
            OP_BEQ, OP_BNE, OP_BLTZ: return K_BR;
            OP_J:                    return K_J;
            OP_HALT:                 return K_HALT;
            default:                 return K_UNK;
        endcase
    endfunction

    function automatic logic [2:0] aluOpOf(input logic [5:0] op);
        case (op)
            OP_SUB:        return 3'b001;
            OP_SLL:        return 3'b010;
            OP_OR, OP_ORI: return 3'b011;
            OP_AND:        return 3'b100;
            OP_SLT:        return 3'b101;
            default:       return 3'b000;
        endcase
    endfunction

    function automatic outs_t sampleDut();
        outs_t o;
        o.pcWre     = bus.PCWre;
        o.irWre     = bus.IRWre;
        o.insMemRw  = bus.InsMemRW;
        o.aluSrcA   = bus.ALUSrcA;
        o.aluSrcB   = bus.ALUSrcB;
        o.dbDataSrc = bus.DBDataSrc;
        o.regWre    = bus.RegWre;
        o.regDst    = bus.RegDst;
        o.extSel    = bus.ExtSel;
        o.mRd       = bus.mRD;
        o.mWr       = bus.mWR;
        o.pcSrc     = bus.PCSrc;
        o.aluOp     = bus.ALUOp;
        o.halted    = bus.halted;
        return o;
    endfunction

    // Reference model: push the expected per-cycle control vectors of one instruction.
    task automatic pushExpected(input logic [5:0] op, input logic [1:0] pcSrc);
        outs_t base;
        outs_t v;
        base = '0;
        base.extSel = (op != OP_ORI);
        v = base; v.irWre = 1'b1; v.insMemRw = 1'b1;
        sb.push_back(v);
        v = base;
        case (kindOf(op))
            K_J, K_UNK: begin
                v.pcWre = 1'b1; v.pcSrc = pcSrc;
                sb.push_back(v);
            end
            K_HALT: sb.push_back(v);
            K_BR: begin
                sb.push_back(v);
                v = base; v.aluOp = 3'b001; v.pcWre = 1'b1; v.pcSrc = pcSrc;
                sb.push_back(v);
            end
            K_ALU: begin
                sb.push_back(v);
                v = base; v.aluOp = aluOpOf(op);
                v.aluSrcB = (op == OP_ADDI) || (op == OP_ORI);
                v.aluSrcA = (op == OP_SLL);
                sb.push_back(v);
                v = base; v.regWre = 1'b1; v.pcWre = 1'b1; v.pcSrc = pcSrc;
                v.regDst = !((op == OP_ADDI) || (op == OP_ORI));
                sb.push_back(v);
            end
            K_LW: begin
                sb.push_back(v);
                v = base; v.aluSrcB = 1'b1; sb.push_back(v);
                v = base; v.mRd = 1'b1; sb.push_back(v);
                v = base; v.regWre = 1'b1; v.dbDataSrc = 1'b1; v.pcWre = 1'b1; v.pcSrc = pcSrc;
                sb.push_back(v);
            end
            K_SW: begin
                sb.push_back(v);
                v = base; v.aluSrcB = 1'b1; sb.push_back(v);
                v = base; v.mWr = 1'b1; v.pcWre = 1'b1; v.pcSrc = pcSrc;
                sb.push_back(v);
            end
            default: ;
        endcase
    endtask

    // Pop the next expected vector and compare it with what the DUT drives right now.
    task automatic checkOutput(input string name, input int cyc);
        outs_t exp;
        outs_t got;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: no expected entry queued", name, cyc);
            return;
        end
        exp = sb.pop_front();
        got = sampleDut();
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got=%05h want=%05h", name, cyc, got, exp);
        end
    endtask

    // Drive one instruction from its IF cycle and check up to maxCycles of its control vectors.
    task automatic applyStimulus(input logic [5:0] op, input logic z, input logic s,
                                 input logic [1:0] pcSrc, input string name, input int maxCycles);
        int n;
        bus.Opcode = op;
        bus.zero   = z;
        bus.sign   = s;
        pushExpected(op, pcSrc);
        n = (sb.size() < maxCycles) ? sb.size() : maxCycles;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checkOutput(name, k + 1);
            @(posedge clk);
            #1;
        end
        sb.delete();
    endtask

    task automatic checkAllZero(input string name);
        outs_t z;
        z = '0;
        sb.push_back(z);
        checkOutput(name, 0);
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,  1'b1, 1'b0, 2'b00, "add"};
        vecs[1]  = '{OP_SUB,  1'b0, 1'b1, 2'b00, "sub"};
        vecs[2]  = '{OP_ADDI, 1'b0, 1'b0, 2'b00, "addi"};
        vecs[3]  = '{OP_OR,   1'b0, 1'b0, 2'b00, "or"};
        vecs[4]  = '{OP_AND,  1'b0, 1'b0, 2'b00, "and"};
        vecs[5]  = '{OP_ORI,  1'b0, 1'b0, 2'b00, "ori"};
        vecs[6]  = '{OP_SLL,  1'b0, 1'b0, 2'b00, "sll"};
        vecs[7]  = '{OP_SLT,  1'b0, 1'b1, 2'b00, "slt"};
        vecs[8]  = '{OP_SW,   1'b0, 1'b0, 2'b00, "sw"};
        vecs[9]  = '{OP_LW,   1'b0, 1'b0, 2'b00, "lw"};
        vecs[10] = '{OP_BEQ,  1'b1, 1'b0, 2'b01, "beqTaken"};
        vecs[11] = '{OP_BEQ,  1'b0, 1'b1, 2'b00, "beqNotTaken"};
        vecs[12] = '{OP_BNE,  1'b1, 1'b0, 2'b00, "bneNotTaken"};
        vecs[13] = '{OP_BNE,  1'b0, 1'b0, 2'b01, "bneTaken"};
        vecs[14] = '{OP_BLTZ, 1'b0, 1'b1, 2'b01, "bltzTaken"};
        vecs[15] = '{OP_BLTZ, 1'b1, 1'b0, 2'b00, "bltzNotTaken"};
        vecs[16] = '{OP_J,    1'b0, 1'b0, 2'b11, "jump"};
        vecs[17] = '{OP_UNK,  1'b0, 1'b0, 2'b00, "unknown"};

        reset      = 1'b1;
        bus.Opcode = OP_ADD;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("resetState");
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].zero, vecs[i].sign, vecs[i].pcSrc, vecs[i].name, 16);
        end

        // Abort an add in EXE_AL with a mid-cycle reset, then restart cleanly.
        applyStimulus(OP_ADD, 1'b0, 1'b0, 2'b00, "abortAdd", 2);
        #2 reset = 1'b1;
        #1 checkAllZero("resetMidExe");
        @(negedge clk);
        checkAllZero("resetHeld");
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(OP_ADD, 1'b0, 1'b0, 2'b00, "addAfterAbort", 16);

        // Fresh run of add, lw, j, halt followed by a long stay in HALT.
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("resetAgain");
        @(posedge clk);
        #1 reset = 1'b0;
        applyStimulus(OP_ADD,  1'b0, 1'b0, 2'b00, "seqAdd", 16);
        applyStimulus(OP_LW,   1'b0, 1'b0, 2'b00, "seqLw", 16);
        applyStimulus(OP_J,    1'b0, 1'b0, 2'b11, "seqJ", 16);
        applyStimulus(OP_HALT, 1'b0, 1'b0, 2'b00, "seqHalt", 16);
        for (int k = 0; k < 100; k++) begin
            outs_t h;
            h = '0;
            h.halted = 1'b1;
            h.extSel = 1'b1;
            bus.Opcode = (k % 2 == 0) ? OP_HALT : OP_J;
            if (bus.Opcode == OP_J) bus.Opcode = OP_HALT;
            @(negedge clk);
            sb.push_back(h);
            checkOutput("haltHold", k);
            @(posedge clk);
        end

`ifdef MCC_PERF_CNT_EN
        #1;
        total++;
        if (bus.instr_cnt !== 32'd3) begin
            bad++;
            $display("[TB] FAIL instrCnt: got=%0d want=3", bus.instr_cnt);
        end
        total++;
        if (bus.cycle_cnt !== 32'd13) begin
            bad++;
            $display("[TB] FAIL cycleCnt: got=%0d want=13", bus.cycle_cnt);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
